data_cache_ctrl: RTL
====================

# data_cache_ctrl

Direct-mapped, write-back data cache controller between the CPU datapath and main data memory. The ALU `RESULT` supplies `ADDRESS`, and register-file data supplies `WRITEDATA`. Hits are serviced with zero stall cycles. Misses stall the CPU through `BUSYWAIT` while a 4-byte block is written back and/or fetched over a 32-bit memory handshake.

## Interface
- Parameters: none. Geometry is fixed at 8 blocks × 4 bytes; tag = `ADDRESS[7:5]`, index = `ADDRESS[4:2]`, offset = `ADDRESS[1:0]`.
- `CLK` input 1 — single clock, rising edge.
- `RESET` input 1 — synchronous, active-high.
- `READ` input 1 — CPU load request.
- `WRITE` input 1 — CPU store request; has priority if `READ` is also high.
- `ADDRESS` input 8 — byte address from the ALU result.
- `WRITEDATA` input 8 — store data.
- `READDATA` output 8 — load data.
- `BUSYWAIT` output 1 — stall the CPU (PC hold, regfile write inhibit).
- `MEM_READ` output 1 — block fetch request.
- `MEM_WRITE` output 1 — block write-back request.
- `MEM_ADDRESS` output 6 — block address {tag, index}.
- `MEM_WRITEDATA` output 32 — write-back block; byte 0 = bits [7:0].
- `MEM_READDATA` input 32 — fetched block.
- `MEM_BUSYWAIT` input 1 — memory operation in progress.

## Operation
- Storage is 8 entries of {valid, dirty, tag[2:0], data[31:0]}.
- Hit condition: `valid[index]` is set and `tag[index] == ADDRESS[7:5]`.
- FSM states: `IDLE`, `WRITEBACK`, `FETCH`, `UPDATE`.
- `IDLE`, no request: `BUSYWAIT` = 0.
- `IDLE`, read hit: `READDATA` = selected byte, combinational; `BUSYWAIT` = 0.
- `IDLE`, write hit: at the clock edge, the byte at offset is written and `dirty` is set; `BUSYWAIT` = 0.
- `IDLE`, miss: `BUSYWAIT` = 1 combinationally.
  - Next state is `WRITEBACK` if the indexed entry is valid and dirty.
  - Otherwise next state is `FETCH`.
- `WRITEBACK`:
  - Outputs: `MEM_WRITE` = 1, `MEM_ADDRESS` = {stored tag, index}, `MEM_WRITEDATA` = stored block.
  - Goes to `FETCH` at the first edge with `MEM_BUSYWAIT` = 0.
- `FETCH`:
  - Outputs: `MEM_READ` = 1, `MEM_ADDRESS` = {`ADDRESS[7:5]`, index}.
  - Goes to `UPDATE` at the first edge with `MEM_BUSYWAIT` = 0; `MEM_READDATA` is captured at that edge.
- `UPDATE`:
  - The captured block is written into the entry, with tag set, valid = 1 and dirty = 0.
  - `BUSYWAIT` = 1; next state is `IDLE`.
  - `IDLE` then re-evaluates the request as a hit, so a store completes there.
- `MEM_READ` and `MEM_WRITE` are never high simultaneously, and are 0 in `IDLE` and `UPDATE`.
- The CPU holds `READ`, `WRITE`, `ADDRESS` and `WRITEDATA` stable while `BUSYWAIT` is high. Changing them mid-miss is undefined.

## Timing
- Reset values: state `IDLE`; all valid, dirty, tag and data cleared.
  - Outputs: `BUSYWAIT` = 0, `MEM_READ` = 0, `MEM_WRITE` = 0, `MEM_ADDRESS` = 0, `MEM_WRITEDATA` = 0, `READDATA` = 0.
- Reset mid-miss: `IDLE` is entered at the next edge and memory requests drop. Dirty data is discarded; no partial update is made.
- Hit latency: 0 stall cycles.
- Clean-miss stall, memory latency L cycles (`MEM_BUSYWAIT` low on the L-th request cycle): 1 (`IDLE`) + L (`FETCH`) + 1 (`UPDATE`) cycles.
- Dirty-miss stall: 1 + L + L + 1 cycles.
- Memory requests are registered-state outputs: they are stable for the whole transaction and drop on the cycle after the completing edge.
- `READ` and `WRITE` both high: treated as a write.

## Configuration
- Macro: `DCACHE_STATS_EN`.
- When defined, two output ports are added:
  - `HIT_COUNT[15:0]` increments once per request serviced as a hit in `IDLE`.
  - `MISS_COUNT[15:0]` increments once per miss detection (`IDLE` → `WRITEBACK`/`FETCH`).
  - Both counters saturate at 16'hFFFF and clear on `RESET`.
  - The re-evaluated hit after `UPDATE` is not counted.
- When undefined: ports and counters are absent, with identical functional behaviour.

## Test plan
Memory model for all scenarios: L = 5.
- Reset, then read 0x00 → `BUSYWAIT` high for 7 cycles; `MEM_READ` high with `MEM_ADDRESS` 0x00 for 5 cycles; `READDATA` = byte 0 of the model block.
- After the first scenario, read 0x01, 0x02 and 0x03 back-to-back → 0 stall cycles; each returns the correct byte.
- Write 0xAB to 0x05 (clean miss), then read 0x05 → write stalls 7 cycles; the read returns 0xAB with no stall; no `MEM_WRITE` occurs.
- With index 1 dirty, read 0x25 (same index, tag 1) → `MEM_WRITE` with address 0x01 and data containing 0xAB at byte 1 for 5 cycles, then `MEM_READ` with address 0x09; total stall 12 cycles.
- Assert `RESET` on the 3rd cycle of `FETCH` → next edge: `MEM_READ` = 0, `BUSYWAIT` = 0; a subsequent read of the same address misses again.
- With `DCACHE_STATS_EN`, run the first two scenarios → `HIT_COUNT` = 3, `MISS_COUNT` = 1.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// ============================================================================
// Module   : data_cache_ctrl
// Purpose  : Direct-mapped write-back data cache, 8 blocks x 4 bytes, with a
//            32-bit block handshake to memory. Optional DCACHE_STATS_EN adds
//            saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_cache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
`ifdef DCACHE_STATS_EN
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT,
`endif
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } t_state;

  t_state      r_state;
  t_state      w_next;

  logic        r_valid [8];
  logic        r_dirty [8];
  logic [2:0]  r_tag   [8];
  logic [31:0] r_data  [8];
  logic [31:0] r_fill;

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic        w_req;
  logic        w_hit;
  logic        w_wr_hit;

  assign w_tag    = ADDRESS[7:5];
  assign w_index  = ADDRESS[4:2];
  assign w_offset = ADDRESS[1:0];
  assign w_req    = READ | WRITE;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_wr_hit = (r_state == IDLE) && WRITE && w_hit;

  assign READDATA = r_data[w_index][{w_offset, 3'b000} +: 8];

  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          BUSYWAIT = 1'b1;
          w_next   = (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[w_index], w_index};
        MEM_WRITEDATA = r_data[w_index];
        if (!MEM_BUSYWAIT) w_next = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {w_tag, w_index};
        if (!MEM_BUSYWAIT) w_next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_fill  <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
        r_tag[i]   <= 3'd0;
        r_data[i]  <= 32'd0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && !MEM_BUSYWAIT) r_fill <= MEM_READDATA;
      if (r_state == UPDATE) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
        r_tag[w_index]   <= w_tag;
        r_data[w_index]  <= r_fill;
      end
      // A store lands only once the block is resident, so misses retry here.
      if (w_wr_hit) begin
        r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic r_from_update;
  logic w_hit_evt;
  logic w_miss_evt;

  // The hit that completes a serviced miss belongs to that miss, not a new hit.
  assign w_hit_evt  = (r_state == IDLE) && w_req && w_hit && !r_from_update;
  assign w_miss_evt = (r_state == IDLE) && w_req && !w_hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_from_update <= 1'b0;
      HIT_COUNT     <= 16'd0;
      MISS_COUNT    <= 16'd0;
    end else begin
      r_from_update <= (r_state == UPDATE);
      if (w_hit_evt && HIT_COUNT != 16'hFFFF)   HIT_COUNT  <= HIT_COUNT + 16'd1;
      if (w_miss_evt && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
